instr_fetch_unit: RTL and testbench

- Produces the instruction fields (op, funct3, funct7) and the PC that the control unit and datapath consume.
- Consumes the control unit's branch decision (pc_src) and the datapath's target to select the next PC.
- Fetches from instruction memory with one outstanding request and a req/ready/rvalid handshake.
- Holds each fetched instruction stable until the core accepts it, so a multi-cycle or stalling datapath can sit behind the decoder.

---
 rtl/instr_fetch_unit.sv | 96 +++++++++
 tb/tb_instr_fetch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: a FETCH/WAIT/HOLD sequencer with one outstanding imem request.
// It holds each fetched word until the core consumes it, then selects the next PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] next_pc;

    // Redirect targets are forced word-aligned, so their low bits never matter.
    logic unused_target_bits;
    assign unused_target_bits = ^pc_target[1:0];

    always_comb begin
        // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
        next_pc = pc + 32'd4;
        if (pc_src) begin
            next_pc = {pc_target[31:2], 2'b00};
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    // Stall wins over a redirect; pc_src is only sampled on the consuming cycle.
                    if (!stall) begin
                        pc          <= next_pc;
                        fetch_count <= fetch_count + 32'd1;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign imem_req  = (state == FETCH) && !rst;
    assign imem_addr = pc;

    // Fields come from the held register only, never straight from imem_rdata.
    assign op     = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a lockstep imem model pushes the expected
// {instr, pc} at request acceptance and the scoreboard pops it when instr_valid rises.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] fetch_count;

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_held(input string tag, input exp_t e);
        check({tag, ".valid"},  32'(instr_valid), 32'd1);
        check({tag, ".instr"},  instr,            e.word);
        check({tag, ".pc"},     instr_pc,         e.addr);
        check({tag, ".op"},     32'(op),          32'(e.word[6:0]));
        check({tag, ".funct3"}, 32'(funct3),      32'(e.word[14:12]));
        check({tag, ".funct7"}, 32'(funct7),      32'(e.word[31:25]));
    endtask

    // One fetch from the FETCH state; ends back in FETCH after the consume, or in HOLD if !consume.
    task automatic fetch_one(input logic [31:0] word, input int ready_dly, input int rvalid_dly,
                             input bit spurious, input int stall_cycles, input bit consume,
                             input bit take, input logic [31:0] target);
        exp_t e;
        check("fetch.req",   32'(imem_req),    32'd1);
        check("fetch.addr",  imem_addr,        exp_pc);
        check("fetch.valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < ready_dly; i++) begin
            imem_ready  = 1'b0;
            imem_rvalid = spurious && (i == 0);
            imem_rdata  = 32'hDEAD_BEEF;
            step();
            check("fetch_wait.req",  32'(imem_req), 32'd1);
            check("fetch_wait.addr", imem_addr,     exp_pc);
            check("fetch_wait.instr_not_spurious", 32'(instr == 32'hDEAD_BEEF), 32'd0);
        end
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        step();
        imem_ready = 1'b0;
        sb_q.push_back('{word: word, addr: exp_pc});
        check("wait.req", 32'(imem_req), 32'd0);
        for (int i = 0; i < rvalid_dly; i++) begin
            step();
            check("wait.valid_low", 32'(instr_valid), 32'd0);
            check("wait.req_low",   32'(imem_req),    32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (sb_q.size() == 0) begin
            check("sb.empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check_held("hold", e);
        for (int i = 0; i < stall_cycles; i++) begin
            stall       = 1'b1;
            pc_src      = i[0];
            pc_target   = 32'h0000_0F00;
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBAAD_F00D;
            step();
            check_held("stall", e);
            check("stall.req",   32'(imem_req),  32'd0);
            check("stall.pc",    imem_addr,      exp_pc);
            check("stall.count", fetch_count,    exp_count);
        end
        imem_rvalid = 1'b0;
        stall       = 1'b0;
        pc_src      = take;
        pc_target   = target;
        if (!consume) return;
        step();
        pc_src    = 1'b0;
        pc_target = 32'h0;
        exp_pc    = take ? {target[31:2], 2'b00} : exp_pc + 32'd4;
        exp_count = exp_count + 32'd1;
        check("consume.valid", 32'(instr_valid), 32'd0);
        check("consume.count", fetch_count,      exp_count);
        check("consume.req",   32'(imem_req),    32'd1);
        check("consume.addr",  imem_addr,        exp_pc);
    endtask

    task automatic check_reset_cycle(input string tag);
        check({tag, ".req"},    32'(imem_req),    32'd0);
        check({tag, ".valid"},  32'(instr_valid), 32'd0);
        check({tag, ".instr"},  instr,            NOP_INSTR);
        check({tag, ".op"},     32'(op),          32'h13);
        check({tag, ".funct3"}, 32'(funct3),      32'd0);
        check({tag, ".funct7"}, 32'(funct7),      32'd0);
        check({tag, ".count"},  fetch_count,      32'd0);
        check({tag, ".ipc"},    instr_pc,         RESET_PC);
    endtask

    initial begin
        rst         = 1'b1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        stall       = 1'b0;
        pc_src      = 1'b0;
        pc_target   = 32'h0;
        exp_pc      = RESET_PC;
        exp_count   = 32'd0;
        step();
        step();
        check_reset_cycle("reset");
        rst = 1'b0;
        #1;

        // Zero-wait memory: three cycles per instruction.
        fetch_one(32'h0050_0093, 0, 0, 1'b0, 0, 1'b1, 1'b0, 32'h0);
        fetch_one(32'h00A0_0113, 0, 0, 1'b0, 0, 1'b1, 1'b0, 32'h0);
        check("two_consumes", fetch_count, 32'd2);

        // ready low for 3 cycles, then a 5-cycle rvalid delay with a spurious rvalid in FETCH.
        fetch_one(32'h00C0_0193, 3, 0, 1'b0, 0, 1'b1, 1'b0, 32'h0);
        fetch_one(32'h00F0_0213, 2, 5, 1'b1, 0, 1'b1, 1'b0, 32'h0);

        // sub held under stall with pc_src toggling, then redirect to an unaligned target.
        fetch_one(32'h40B5_0533, 0, 1, 1'b0, 4, 1'b1, 1'b1, 32'h0000_0103);
        check("redirect.addr", imem_addr, 32'h0000_0100);

        // Redirect to the top word, then wrap pc+4 to zero.
        fetch_one(32'h0000_0013, 0, 0, 1'b0, 0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        check("top.addr", imem_addr, 32'hFFFF_FFFC);
        fetch_one(32'h0010_0293, 1, 2, 1'b0, 1, 1'b1, 1'b0, 32'h0);
        check("wrap.addr", imem_addr, 32'h0000_0000);
        check("count7", fetch_count, 32'd7);

        // Reset while holding an instruction.
        fetch_one(32'h0020_0313, 0, 0, 1'b0, 1, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        check_reset_cycle("rst_hold");
        rst = 1'b0;
        #1;
        exp_pc    = RESET_PC;
        exp_count = 32'd0;
        check("rst_hold.req_after",  32'(imem_req), 32'd1);
        check("rst_hold.addr_after", imem_addr,     RESET_PC);

        // Reset while waiting on a response; the late rvalid must be dropped.
        fetch_one(32'h0030_0393, 0, 0, 1'b0, 0, 1'b1, 1'b0, 32'h0);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        rst = 1'b1;
        step();
        check_reset_cycle("rst_wait");
        rst = 1'b0;
        exp_pc    = RESET_PC;
        exp_count = 32'd0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check("rst_wait.no_capture", 32'(instr_valid), 32'd0);
        check("rst_wait.instr_nop",  instr,            NOP_INSTR);
        fetch_one(32'h0040_0413, 0, 0, 1'b0, 0, 1'b1, 1'b0, 32'h0);
        check("sb.drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
